int8_row_requant: RTL and testbench

- Downstream stage of the int8 8x8 matrix-multiply wrapper.
- Consumes the result matrix C as an AXI-Stream of 8 rows × 128 bits (8 signed int16 lanes per row).
- Requantizes each lane to int8 (scale, rounding shift, zero-point add, saturate) and emits 8 rows × 64 bits with TLAST on row 7.
- Runs under the same ap_ctrl start/done/continue protocol so it can be chained after the multiply block.

---
 rtl/int8_row_requant_pkg.sv | 26 ++
 rtl/int8_row_requant_lane.sv | 59 +++++
 rtl/int8_row_requant.sv | 134 +++++++++++++
 tb/tb_int8_row_requant.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/int8_row_requant_pkg.sv
// Shared constants, FSM state type and saturation limits for the int8 row requantizer.
package int8_row_requant_pkg;

  localparam int LANES   = 8;   // int lanes per row
  localparam int IN_W    = 16;  // signed input lane width
  localparam int OUT_W   = 8;   // signed output lane width
  localparam int ROWS    = 8;   // rows per matrix frame
  localparam int SHIFT_W = 5;   // width of the right-shift amount

  localparam int SCALE_W = 16;
  localparam int ZP_W    = 8;
  localparam int PROD_W  = IN_W + SCALE_W;  // lane x scale
  localparam int RND_W   = PROD_W + 1;      // product plus rounding term
  localparam int SUM_W   = RND_W + 1;       // shifted value plus zero point
  localparam int CNT_W   = $clog2(ROWS + 1);

  localparam logic signed [SUM_W-1:0] INT8_MIN = SUM_W'(-128);
  localparam logic signed [SUM_W-1:0] INT8_MAX = SUM_W'(127);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/int8_row_requant_lane.sv
// Three-stage per-lane requantization datapath: multiply, rounding shift,
// zero-point add with int8 saturation. Each stage loads only when enabled.
module requant_lane
  import int8_row_requant_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_s1,
  input  logic                en_s2,
  input  logic                en_s3,
  input  logic [IN_W-1:0]     lane_in,
  input  logic [SCALE_W-1:0]  scale,
  input  logic [SHIFT_W-1:0]  shift,
  input  logic [ZP_W-1:0]     zero_point,
  output logic [OUT_W-1:0]    lane_out
);

  logic signed [PROD_W-1:0] p_d, p_q;
  logic signed [RND_W-1:0]  rnd;
  logic signed [RND_W-1:0]  sum;
  logic signed [RND_W-1:0]  r_d, r_q;
  logic signed [SUM_W-1:0]  y_full;
  logic        [OUT_W-1:0]  y_d, y_q;

  // Next-value logic for all three stages.
  always_comb begin
    // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
    rnd = '0;
    if (shift != '0) rnd = RND_W'(1) << (shift - SHIFT_W'(1));

    p_d    = $signed(lane_in) * $signed(scale);
    sum    = {p_q[PROD_W-1], p_q} + rnd;
    r_d    = sum >>> shift;
    y_full = {r_q[RND_W-1], r_q} + {{(SUM_W-ZP_W){zero_point[ZP_W-1]}}, zero_point};

    if (y_full > INT8_MAX)      y_d = INT8_MAX[OUT_W-1:0];
    else if (y_full < INT8_MIN) y_d = INT8_MIN[OUT_W-1:0];
    else                        y_d = y_full[OUT_W-1:0];
  end

  // Stage registers, each held while its enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset too, because the last stage drives q_tdata
    //       and the output must read zero straight out of reset.
    if (!rst_n) begin
      // NOTE: non-blocking assignments keep every stage sampling the pre-edge value of the one before.
      p_q <= '0;
      r_q <= '0;
      y_q <= '0;
    end else begin
      if (en_s1) p_q <= p_d;
      if (en_s2) r_q <= r_d;
      if (en_s3) y_q <= y_d;
    end
  end

  assign lane_out = y_q;

endmodule

// File: rtl/int8_row_requant.sv
// Requantizes an 8-row int16 result matrix to int8 rows under ap_ctrl
// start/done/continue handshaking with AXI-Stream input and output.
module int8_row_requant
  import int8_row_requant_pkg::*;
(
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_start,
  output logic                    ap_idle,
  output logic                    ap_ready,
  output logic                    ap_done,
  input  logic                    ap_continue,
  input  logic [SCALE_W-1:0]      cfg_scale,
  input  logic [SHIFT_W-1:0]      cfg_shift,
  input  logic [ZP_W-1:0]         cfg_zero_point,
  input  logic [LANES*IN_W-1:0]   c_tdata,
  input  logic                    c_tvalid,
  output logic                    c_tready,
  output logic [LANES*OUT_W-1:0]  q_tdata,
  output logic                    q_tvalid,
  input  logic                    q_tready,
  output logic                    q_tlast
);

  state_t             state_d, state_q;
  logic [CNT_W-1:0]   rows_in_d, rows_in_q;
  logic [CNT_W-1:0]   rows_out_d, rows_out_q;
  logic [SCALE_W-1:0] scale_d, scale_q;
  logic [SHIFT_W-1:0] shift_d, shift_q;
  logic [ZP_W-1:0]    zp_d, zp_q;
  logic               v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  logic               last1_d, last1_q, last2_d, last2_q, last3_d, last3_q;
  logic               en_s1, en_s2, en_s3;
  logic               in_acc, out_hs;

  // Pipeline stall chain, stream handshakes, FSM and counters.
  always_comb begin
    en_s3    = !v3_q || q_tready;
    en_s2    = !v2_q || en_s3;
    en_s1    = !v1_q || en_s2;
    c_tready = (state_q == RUN) && (rows_in_q < CNT_W'(ROWS)) && en_s1;
    in_acc   = c_tvalid && c_tready;
    out_hs   = v3_q && q_tready;

    v1_d    = en_s1 ? in_acc : v1_q;
    last1_d = en_s1 ? (in_acc && (rows_in_q == CNT_W'(ROWS - 1))) : last1_q;
    v2_d    = en_s2 ? v1_q : v2_q;
    last2_d = en_s2 ? last1_q : last2_q;
    v3_d    = en_s3 ? v2_q : v3_q;
    last3_d = en_s3 ? last2_q : last3_q;

    state_d    = state_q;
    rows_in_d  = rows_in_q;
    rows_out_d = rows_out_q;
    scale_d    = scale_q;
    shift_d    = shift_q;
    zp_d       = zp_q;

    case (state_q)
      IDLE: begin
        if (ap_start) begin
          state_d    = RUN;
          rows_in_d  = '0;
          rows_out_d = '0;
          scale_d    = cfg_scale;
          shift_d    = cfg_shift;
          zp_d       = cfg_zero_point;
        end
      end
      RUN: begin
        if (in_acc) rows_in_d  = rows_in_q + CNT_W'(1);
        if (out_hs) rows_out_d = rows_out_q + CNT_W'(1);
        if (out_hs && (rows_out_q == CNT_W'(ROWS - 1))) state_d = DONE;
      end
      DONE: begin
        if (ap_continue) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      rows_in_q  <= '0;
      rows_out_q <= '0;
      scale_q    <= '0;
      shift_q    <= '0;
      zp_q       <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      last1_q    <= 1'b0;
      last2_q    <= 1'b0;
      last3_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_in_q  <= rows_in_d;
      rows_out_q <= rows_out_d;
      scale_q    <= scale_d;
      shift_q    <= shift_d;
      zp_q       <= zp_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      v3_q       <= v3_d;
      last1_q    <= last1_d;
      last2_q    <= last2_d;
      last3_q    <= last3_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_lane u_lane (
      .clk        (ap_clk),
      .rst_n      (ap_rst_n),
      .en_s1      (en_s1),
      .en_s2      (en_s2),
      .en_s3      (en_s3),
      .lane_in    (c_tdata[IN_W*i +: IN_W]),
      .scale      (scale_q),
      .shift      (shift_q),
      .zero_point (zp_q),
      .lane_out   (q_tdata[OUT_W*i +: OUT_W])
    );
  end

  assign ap_idle  = (state_q == IDLE);
  assign ap_ready = (state_q == IDLE);
  assign ap_done  = (state_q == DONE);
  assign q_tvalid = v3_q;
  assign q_tlast  = last3_q;

endmodule

// File: tb/tb_int8_row_requant.sv
// Self-checking bench for int8_row_requant: directed frames plus randomized
// rows, stalls and gaps checked against an arithmetic reference model.
module tb_int8_row_requant;
  import int8_row_requant_pkg::*;

  logic                    ap_clk = 1'b0;
  logic                    ap_rst_n;
  logic                    ap_start, ap_idle, ap_ready, ap_done, ap_continue;
  logic [15:0]             cfg_scale;
  logic [SHIFT_W-1:0]      cfg_shift;
  logic [7:0]              cfg_zero_point;
  logic [LANES*IN_W-1:0]   c_tdata;
  logic                    c_tvalid, c_tready;
  logic [LANES*OUT_W-1:0]  q_tdata;
  logic                    q_tvalid, q_tready, q_tlast;

  always #5 ap_clk = ~ap_clk;

  int8_row_requant dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_idle(ap_idle),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_zero_point(cfg_zero_point),
    .c_tdata(c_tdata), .c_tvalid(c_tvalid), .c_tready(c_tready),
    .q_tdata(q_tdata), .q_tvalid(q_tvalid), .q_tready(q_tready), .q_tlast(q_tlast)
  );

  int tests = 0;
  int fails = 0;

  logic [LANES*IN_W-1:0]  rows [ROWS+1];
  logic [LANES*OUT_W-1:0] exp_q [$];
  logic [LANES*OUT_W-1:0] outs [$];
  int m_scale, m_shift, m_zp;
  int lat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the configuration latched at start.
  function automatic logic [LANES*OUT_W-1:0] model_row(input logic [LANES*IN_W-1:0] in);
    logic [LANES*OUT_W-1:0] res;
    longint x, v;
    for (int i = 0; i < LANES; i++) begin
      x = $signed(in[IN_W*i +: IN_W]);
      v = x * m_scale;
      if (m_shift > 0) v = v + (longint'(1) << (m_shift - 1));
      v = v >>> m_shift;
      v = v + m_zp;
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
      res[OUT_W*i +: OUT_W] = v[7:0];
    end
    return res;
  endfunction

  task automatic random_rows(input int from);
    for (int r = from; r <= ROWS; r++)
      for (int i = 0; i < LANES; i++) rows[r][IN_W*i +: IN_W] = 16'($urandom);
  endtask

  task automatic start_frame(input logic [15:0] sc, input logic [SHIFT_W-1:0] sh,
                             input logic [7:0] zp);
    @(negedge ap_clk);
    cfg_scale = sc; cfg_shift = sh; cfg_zero_point = zp; ap_start = 1'b1;
    m_scale = $signed(sc); m_shift = int'(sh); m_zp = $signed(zp);
    @(negedge ap_clk);
    ap_start = 1'b0;
    check("start_leaves_idle", ap_idle, 0);
  endtask

  // Cycle loop: drive at negedge, evaluate handshakes #1 later, edge commits them.
  task automatic run_frame(input int n_offer, input int acc_stop, input int vprob,
                           input int rprob, input bit scramble_cfg, output int latency);
    int sent = 0, got = 0, cyc = 0, first_acc = -1, first_vld = -1;
    bit prev_stall = 0, finished = 0, acc, emit;
    logic [63:0] pd;
    logic pl;
    outs.delete();
    while (cyc < 2000) begin
      @(negedge ap_clk);
      cyc++;
      if (prev_stall) begin
        check("stall_data_stable", q_tdata, pd);
        check("stall_last_stable", q_tlast, pl);
      end
      if (got == ROWS) begin
        check("done_after_last", ap_done, 1);
        check("no_extra_row", q_tvalid, 0);
        finished = 1;
        break;
      end
      if (q_tvalid && first_vld < 0) first_vld = cyc;
      if (scramble_cfg) begin
        cfg_scale = 16'($urandom); cfg_shift = SHIFT_W'($urandom); cfg_zero_point = 8'($urandom);
      end
      q_tready = ($urandom_range(99) < rprob);
      c_tvalid = (sent < n_offer) && ($urandom_range(99) < vprob);
      c_tdata  = rows[(sent < n_offer) ? sent : 0];
      #1;
      acc  = c_tvalid && c_tready;
      emit = q_tvalid && q_tready;
      if (sent == ROWS) check("no_ninth_accept", c_tready, 0);
      if (emit) begin
        if (exp_q.size() > 0) check($sformatf("row%0d_data", got), q_tdata, exp_q.pop_front());
        else check("unexpected_row", 1, 0);
        check($sformatf("row%0d_last", got), q_tlast, (got == ROWS - 1));
        outs.push_back(q_tdata);
        got++;
      end
      if (acc) begin
        if (first_acc < 0) first_acc = cyc;
        exp_q.push_back(model_row(c_tdata));
        sent++;
      end
      prev_stall = q_tvalid && !q_tready;
      pd = q_tdata;
      pl = q_tlast;
      if (acc_stop >= 0 && sent == acc_stop) begin
        finished = 1;
        break;
      end
    end
    if (!finished) check("frame_timeout", 0, 1);
    latency = first_vld - first_acc;
  endtask

  task automatic finish_frame();
    c_tvalid = 1'b0;
    @(negedge ap_clk);
    check("done_holds", ap_done, 1);
    check("scoreboard_empty", exp_q.size(), 0);
    check("row_count", outs.size(), ROWS);
    ap_continue = 1'b1;
    @(negedge ap_clk);
    ap_continue = 1'b0;
    check("continue_to_idle", ap_idle, 1);
    check("done_cleared", ap_done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ap_rst_n = 1'b0; ap_start = 1'b0; ap_continue = 1'b0;
    cfg_scale = '0; cfg_shift = '0; cfg_zero_point = '0;
    c_tdata = '0; c_tvalid = 1'b0; q_tready = 1'b0;
    #23;
    check("rst_q_tvalid", q_tvalid, 0);
    check("rst_q_tdata", q_tdata, 0);
    check("rst_q_tlast", q_tlast, 0);
    check("rst_c_tready", c_tready, 0);
    check("rst_ap_idle", ap_idle, 1);
    check("rst_ap_ready", ap_ready, 1);
    check("rst_ap_done", ap_done, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Continue outside DONE and start-free cycles leave the block idle.
    ap_continue = 1'b1;
    @(negedge ap_clk);
    ap_continue = 1'b0;
    check("idle_ignores_continue", ap_idle, 1);

    // Frame 1: scale 3, shift 2, zp 0; rows of +100 and -100, full throughput.
    rows[0] = {LANES{16'sd100}};
    rows[1] = {LANES{-16'sd100}};
    random_rows(2);
    start_frame(16'd3, 5'd2, 8'd0);
    run_frame(ROWS, -1, 100, 100, 1'b0, lat);
    check("first_latency", lat, 3);
    if (outs.size() >= 2) begin
      check("plus100_to_75", outs[0], {LANES{8'h4B}});
      check("minus100_to_m75", outs[1], {LANES{8'hB5}});
    end else check("frame1_rows_present", outs.size(), 2);
    finish_frame();

    // Frame 2: shift 0 with zero point and saturation at both ends.
    rows[0] = 128'hFFFF_0000_FF75_FF76_0076_0075_FC18_03E8;
    random_rows(1);
    start_frame(16'd1, 5'd0, 8'd10);
    run_frame(ROWS, -1, 100, 100, 1'b0, lat);
    if (outs.size() >= 1) check("saturate_vector", outs[0], 64'h090A_8080_7F7F_807F);
    else check("frame2_rows_present", outs.size(), 1);
    finish_frame();

    // Frame 3: random cfg, random stalls and gaps, cfg scrambled mid-frame, 9th row offered.
    random_rows(0);
    start_frame(16'($urandom), SHIFT_W'($urandom), 8'($urandom));
    run_frame(ROWS + 1, -1, 70, 50, 1'b1, lat);
    finish_frame();

    // Frame 4: large shifts to exercise the rounding edge near the top of the range.
    random_rows(0);
    start_frame(16'h8000, 5'd31, 8'h85);
    run_frame(ROWS, -1, 60, 60, 1'b0, lat);
    finish_frame();

    // Frame 5: reset after four accepted rows drops everything in flight.
    random_rows(0);
    start_frame(16'd7, 5'd3, 8'hF0);
    run_frame(ROWS, 4, 100, 100, 1'b0, lat);
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    c_tvalid = 1'b0;
    #1;
    check("midrst_q_tvalid", q_tvalid, 0);
    check("midrst_ap_idle", ap_idle, 1);
    check("midrst_c_tready", c_tready, 0);
    exp_q.delete();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Frame 6: fresh frame after the reset yields exactly eight correct rows.
    random_rows(0);
    start_frame(16'($urandom), SHIFT_W'($urandom_range(12)), 8'($urandom));
    run_frame(ROWS, -1, 80, 60, 1'b0, lat);
    finish_frame();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
